// File: rtl/alu_pipe16_pkg.sv
// Shared definitions for the pipelined Hack ALU: widths, ctrl bit positions,
// named ctrl encodings and the operation record carried by stage 1.
package alu_pipe16_pkg;

  localparam int ALU_W  = 16;
  localparam int CTRL_W = 6;

  // Bit positions inside ctrl = {zx,nx,zy,ny,f,no}
  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;

  // Commonly used control words
  localparam logic [CTRL_W-1:0] ALU_AND  = 6'b000000;
  localparam logic [CTRL_W-1:0] ALU_ADD  = 6'b000010;
  localparam logic [CTRL_W-1:0] ALU_OR   = 6'b010101;
  localparam logic [CTRL_W-1:0] ALU_ZERO = 6'b101010;
  localparam logic [CTRL_W-1:0] ALU_ONE  = 6'b111111;

  // One accepted operation as held in stage 1
  typedef struct packed {
    logic [ALU_W-1:0]  a;
    logic [ALU_W-1:0]  b;
    logic [CTRL_W-1:0] ctrl;
  } alu_op_t;

endpackage

// File: rtl/alu16_core.sv
// Purely combinational 16-bit Hack ALU: zero/invert each operand, then AND or
// ADD, then optionally invert the result. Flags are derived from the result.
module alu16_core
  import alu_pipe16_pkg::*;
(
  input  logic [ALU_W-1:0]  i_a,
  input  logic [ALU_W-1:0]  i_b,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic [ALU_W-1:0]  o_out,
  output logic              o_zr,
  output logic              o_ng
);

  logic [ALU_W-1:0] w_x_zero;
  logic [ALU_W-1:0] w_x;
  logic [ALU_W-1:0] w_y_zero;
  logic [ALU_W-1:0] w_y;
  logic [ALU_W-1:0] w_and;
  logic [ALU_W-1:0] w_sum;
  logic [ALU_W-1:0] w_r;

  // The adder is the only cross-bit unit; carry out of the top bit is dropped.
  assign w_sum = w_x + w_y;

  // Bit-sliced zero/invert/and/select/invert chain.
  genvar gi;
  generate
    for (gi = 0; gi < ALU_W; gi++) begin : g_bit
      assign w_x_zero[gi] = i_a[gi] & ~i_ctrl[CTRL_ZX];
      assign w_x[gi]      = w_x_zero[gi] ^ i_ctrl[CTRL_NX];
      assign w_y_zero[gi] = i_b[gi] & ~i_ctrl[CTRL_ZY];
      assign w_y[gi]      = w_y_zero[gi] ^ i_ctrl[CTRL_NY];
      assign w_and[gi]    = w_x[gi] & w_y[gi];
      assign w_r[gi]      = i_ctrl[CTRL_F] ? w_sum[gi] : w_and[gi];
      assign o_out[gi]    = w_r[gi] ^ i_ctrl[CTRL_NO];
    end
  endgenerate

  assign o_zr = ~|o_out;
  assign o_ng = o_out[ALU_W-1];

endmodule

// File: rtl/alu_pipe16.sv
// Two-stage valid/ready pipeline around alu16_core. Stage 1 registers the
// operation, stage 2 registers the result and flags. Only in_ready is
// combinational (from the stage valids and out_ready); data outputs are
// straight from registers.
module alu_pipe16
  import alu_pipe16_pkg::*;
#(
  parameter int WIDTH = ALU_W
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [CTRL_W-1:0] ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out,
  output logic              zr,
  output logic              ng
);

  logic             r_s1_valid;
  alu_op_t          r_op;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_zr;
  logic             r_ng;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_in_fire;
  logic [WIDTH-1:0] w_core_out;
  logic             w_core_zr;
  logic             w_core_ng;

  // Stage 2 can take a new value when empty or being drained this cycle;
  // stage 1 can take one whenever it is empty or moving into stage 2.
  assign w_s2_adv  = ~r_out_valid | out_ready;
  assign w_s1_adv  = r_s1_valid & w_s2_adv;
  assign in_ready  = ~r_s1_valid | w_s2_adv;
  assign w_in_fire = in_valid & in_ready;

  alu16_core u_core (
    .i_a    (r_op.a),
    .i_b    (r_op.b),
    .i_ctrl (r_op.ctrl),
    .o_out  (w_core_out),
    .o_zr   (w_core_zr),
    .o_ng   (w_core_ng)
  );

  // Stage 1: capture the operation on a handshake; flush wins over a new accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_op       <= '{a: '0, b: '0, ctrl: ALU_AND};
    end else begin
      if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_in_fire) begin
        r_op <= '{a: a, b: b, ctrl: ctrl};
      end
    end
  end

  // Stage 2: take the ALU result whenever the output slot is free or consumed,
  // otherwise hold result and flags steady for the stalled consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_zr        <= 1'b1;
      r_ng        <= 1'b0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
      end
      if (w_s2_adv) begin
        r_out <= w_core_out;
        r_zr  <= w_core_zr;
        r_ng  <= w_core_ng;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign zr        = r_zr;
  assign ng        = r_ng;

endmodule

// File: tb/tb_alu_pipe16.sv
// Self-checking bench for alu_pipe16: directed scenarios plus a randomized
// handshake stream scored against an arithmetic reference model.
module tb_alu_pipe16;
  import alu_pipe16_pkg::*;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a         = 16'h0000;
  logic [15:0] b         = 16'h0000;
  logic [5:0]  ctrl      = 6'b000000;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out;
  logic        zr;
  logic        ng;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  localparam int N_OPS      = 10000;
  localparam int RAND_LIMIT = 40000;

  always #5 clk = ~clk;

  alu_pipe16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng)
  );

  // Reference: the Hack ALU rules in plain integer arithmetic.
  function automatic logic [15:0] ref_alu(input logic [15:0] av, input logic [15:0] bv,
                                          input logic [5:0] c);
    int unsigned x;
    int unsigned y;
    int unsigned r;
    x = c[5] ? 32'd0 : {16'd0, av};
    if (c[4]) x = 32'd65535 - x;
    y = c[3] ? 32'd0 : {16'd0, bv};
    if (c[2]) y = 32'd65535 - y;
    r = c[1] ? ((x + y) % 32'd65536) : (x & y);
    if (c[0]) r = 32'd65535 - r;
    return r[15:0];
  endfunction

  task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv,
                       input logic [5:0] c, input logic ordy);
    in_valid  = v;
    a         = av;
    b         = bv;
    ctrl      = c;
    out_ready = ordy;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, out, zr, ng} !== {1'b0, 16'h0000, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got v=%b out=%h zr=%b ng=%b want v=0 out=0000 zr=1 ng=0",
               out_valid, out, zr, ng);
    end
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 16'h0, ALU_AND, 1'b1);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    drive(1'b1, 16'h0005, 16'h0003, ALU_AND, 1'b1);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    drive(1'b1, 16'h0005, 16'h0003, ALU_OR, 1'b1);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_latency: out_valid got %b want 0 one cycle after accept", out_valid);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 16'h0, 16'h0, ALU_AND, 1'b1);
    @(negedge clk);
    n_vec++;
    if ({out_valid, out, zr, ng} !== {1'b1, 16'h0001, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL basic_and: got v=%b out=%h zr=%b ng=%b want v=1 out=0001 zr=0 ng=0",
               out_valid, out, zr, ng);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_vec++;
    if ({out_valid, out, zr, ng} !== {1'b1, 16'h0007, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL basic_or: got v=%b out=%h zr=%b ng=%b want v=1 out=0007 zr=0 ng=0",
               out_valid, out, zr, ng);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_drain: out_valid got %b want 0", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    drive(1'b1, 16'h7FFF, 16'h0001, ALU_ADD, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b1, 16'hFFFF, 16'h0001, ALU_ADD, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 16'h0, 16'h0, ALU_AND, 1'b1);
    @(negedge clk);
    n_vec++;
    if ({out_valid, out, zr, ng} !== {1'b1, 16'h8000, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL wrap_8000: got v=%b out=%h zr=%b ng=%b want v=1 out=8000 zr=0 ng=1",
               out_valid, out, zr, ng);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_vec++;
    if ({out_valid, out, zr, ng} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL wrap_0000: got v=%b out=%h zr=%b ng=%b want v=1 out=0000 zr=1 ng=0",
               out_valid, out, zr, ng);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [15:0] ta[4];
    logic [15:0] tbv[4];
    logic [5:0]  tc[4];
    logic [15:0] first_exp;
    logic [15:0] e;
    logic [31:0] r32;
    int acc;
    int got;
    int idx;
    acc = 0;
    got = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      r32 = $urandom;
      ta[i] = r32[15:0];
      tbv[i] = r32[31:16];
      r32 = $urandom;
      tc[i] = r32[5:0];
    end
    first_exp = ref_alu(ta[0], tbv[0], tc[0]);
    // Output held off: only two operations fit, the first result must sit still.
    for (int cyc = 0; cyc < 5; cyc++) begin
      idx = (acc < 4) ? acc : 3;
      drive(acc < 4, ta[idx], tbv[idx], tc[idx], 1'b0);
      @(negedge clk);
      if (out_valid) begin
        n_vec++;
        if ({out, zr, ng} !== {first_exp, (first_exp == 16'h0), first_exp[15]}) begin
          n_err++;
          $display("FAIL bp_hold: got out=%h zr=%b ng=%b want out=%h", out, zr, ng, first_exp);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_alu(a, b, ctrl));
        acc++;
      end
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (acc !== 2) begin
      n_err++;
      $display("FAIL bp_accepts: got %0d accepts want 2", acc);
    end
    n_vec++;
    if ({in_ready, out_valid} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_in_ready: got in_ready=%b out_valid=%b want in_ready=0 out_valid=1",
               in_ready, out_valid);
    end
    // Release: every result arrives once, in order.
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      idx = (acc < 4) ? acc : 3;
      drive(acc < 4, ta[idx], tbv[idx], tc[idx], 1'b1);
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL bp_extra: got out=%h want no result", out);
        end else begin
          e = exp_q.pop_front();
          if ({out, zr, ng} !== {e, (e == 16'h0), e[15]}) begin
            n_err++;
            $display("FAIL bp_order: result %0d got out=%h zr=%b ng=%b want out=%h",
                     got, out, zr, ng, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_alu(a, b, ctrl));
        acc++;
      end
      @(posedge clk);
      #1;
    end
    drive(1'b0, 16'h0, 16'h0, ALU_AND, 1'b1);
    @(negedge clk);
    n_vec++;
    if (got !== 4 || exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_count: got %0d results, %0d pending, out_valid=%b want 4, 0, 0",
               got, exp_q.size(), out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    drive(1'b1, 16'h1111, 16'h2222, ALU_ADD, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 16'h3333, 16'h4444, ALU_ADD, 1'b0);
    @(posedge clk);
    #1;
    // Both stages full; flush together with an accepted op.
    flush = 1'b1;
    drive(1'b1, 16'h1234, 16'h4321, ALU_ADD, 1'b1);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_in_ready_during: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0, ALU_AND, 1'b1);
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL flush_after: got out_valid=%b in_ready=%b want out_valid=0 in_ready=1",
               out_valid, in_ready);
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL flush_ghost: got %0d results after flush want 0", seen);
    end
  endtask

  task automatic test_random();
    logic [31:0] r32;
    logic [31:0] r32b;
    logic [15:0] e;
    logic        v;
    logic        ordy;
    logic        prev_stall;
    logic [15:0] prev_out;
    int acc;
    int got;
    int cycles;
    acc = 0;
    got = 0;
    cycles = 0;
    prev_stall = 1'b0;
    prev_out = 16'h0;
    exp_q.delete();
    while ((acc < N_OPS || got < acc) && cycles < RAND_LIMIT) begin
      r32  = $urandom;
      r32b = $urandom;
      v    = (acc < N_OPS) && ($urandom_range(3) != 0);
      ordy = ($urandom_range(3) != 0);
      drive(v, r32[15:0], r32[31:16], r32b[5:0], ordy);
      @(negedge clk);
      if (prev_stall) begin
        n_vec++;
        if ({out_valid, out} !== {1'b1, prev_out}) begin
          n_err++;
          $display("FAIL rand_stall: got v=%b out=%h want v=1 out=%h", out_valid, out, prev_out);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out = out;
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra: got out=%h want no result", out);
        end else begin
          e = exp_q.pop_front();
          if ({out, zr, ng} !== {e, (e == 16'h0), e[15]}) begin
            n_err++;
            $display("FAIL rand_result: op %0d got out=%h zr=%b ng=%b want out=%h zr=%b ng=%b",
                     got, out, zr, ng, e, (e == 16'h0), e[15]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_alu(a, b, ctrl));
        acc++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    drive(1'b0, 16'h0, 16'h0, ALU_AND, 1'b1);
    n_vec++;
    if (acc != N_OPS || got != acc || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_count: accepted %0d results %0d pending %0d want %0d, %0d, 0",
               acc, got, exp_q.size(), N_OPS, N_OPS);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 16'h8000, 16'h0000, ALU_ADD, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, out, zr, ng} !== {1'b1, 16'h8000, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL arst_pre: got v=%b out=%h zr=%b ng=%b want v=1 out=8000 zr=0 ng=1",
               out_valid, out, zr, ng);
    end
    // Assert reset between edges; outputs must clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out, zr, ng, in_ready} !== {1'b0, 16'h0000, 1'b1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL arst_now: got v=%b out=%h zr=%b ng=%b rdy=%b want v=0 out=0000 zr=1 ng=0 rdy=1",
               out_valid, out, zr, ng, in_ready);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 16'h0, ALU_AND, 1'b1);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL arst_leftover: out_valid got %b want 0", out_valid);
    end
    @(posedge clk);
    #1;
    drive(1'b1, 16'h0003, 16'h0004, ALU_ADD, 1'b1);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL arst_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 16'h0, 16'h0, ALU_AND, 1'b1);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL arst_latency: out_valid got %b want 0 one cycle after accept", out_valid);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_vec++;
    if ({out_valid, out, zr, ng} !== {1'b1, 16'h0007, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL arst_first_op: got v=%b out=%h zr=%b ng=%b want v=1 out=0007 zr=0 ng=0",
               out_valid, out, zr, ng);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog timeout");
  end

endmodule
